// File: rtl/sap2_serial_out_port_if.sv
// Signals between the SAP-2 controller-sequencer and serial output port 4.
// The controller drives the load/clear strobes; the port reports line and status.
interface sap2_serial_out_port_if #(
    parameter int DATA_W = 8
);
    logic              iLoad;
    logic [DATA_W-1:0] iData;
    logic              iClrErr;
    logic              oTx;
    logic              oReady;
    logic              oDone;
    logic              oOverrun;
    logic [3:0]        oBitIdx;

    modport master (
        output iLoad, iData, iClrErr,
        input  oTx, oReady, oDone, oOverrun, oBitIdx
    );

    modport slave (
        input  iLoad, iData, iClrErr,
        output oTx, oReady, oDone, oOverrun, oBitIdx
    );
endinterface

// File: rtl/sap2_serial_out_port.sv
// SAP-2 serial output port (port 4): latches a W-bus byte on Lo4 and shifts it
// out as start / LSB-first data / optional parity / stop, with ready/done status.
module sap2_serial_out_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input logic                   iClk,
    input logic                   iReset_n,
    sap2_serial_out_port_if.slave bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_STOP_EXIT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] BIT_LAST      = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_PARITY    = IDX_W'(DATA_W + 1);
    localparam logic [IDX_W-1:0] IDX_STOP      = IDX_W'(DATA_W + 1 + int'(PARITY_EN));

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_e;

    txState_e          state;
    txState_e          stateNext;
    logic [CNT_W-1:0]  baudCnt;
    logic [IDX_W-1:0]  bitCnt;
    logic [DATA_W-1:0] shiftReg;
    logic              parityBit;
    logic              done;
    logic              doneNext;
    logic              overrun;
    logic              bitEnd;
    logic              loadAccept;

    assign bitEnd     = (baudCnt == CNT_LAST);
    assign loadAccept = (state == IDLE) && bus.iLoad;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // STOP exits one cycle early: the last stop-bit cycle is spent in IDLE with
    // oReady/oDone high, so a load there starts the next frame with no gap.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        stateNext   = state;
        doneNext    = 1'b0;
        bus.oTx     = 1'b1;
        bus.oBitIdx = '0;
        unique case (state)
            IDLE: begin
                if (bus.iLoad) stateNext = START;
            end
            START: begin
                bus.oTx = 1'b0;
                if (bitEnd) stateNext = DATA;
            end
            DATA: begin
                bus.oTx     = shiftReg[0];
                bus.oBitIdx = bitCnt + 1'b1;
                if (bitEnd && (bitCnt == BIT_LAST)) stateNext = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
                bus.oTx     = parityBit;
                bus.oBitIdx = IDX_PARITY;
                if (bitEnd) stateNext = STOP;
            end
            STOP: begin
                bus.oBitIdx = IDX_STOP;
                if (baudCnt == CNT_STOP_EXIT) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            baudCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= doneNext;

            if ((state == IDLE) || bitEnd) baudCnt <= '0;
            else                           baudCnt <= baudCnt + 1'b1;

            if (loadAccept) begin
                shiftReg  <= bus.iData;
                parityBit <= (^bus.iData) ^ PARITY_ODD;
                bitCnt    <= '0;
            end else if ((state == DATA) && bitEnd) begin
                shiftReg <= shiftReg >> 1;
                bitCnt   <= bitCnt + 1'b1;
            end

            // A load while busy sets the flag even if a clear arrives on the same edge.
            if (bus.iLoad && (state != IDLE)) overrun <= 1'b1;
            else if (bus.iClrErr)             overrun <= 1'b0;
        end
    end

    assign bus.oReady   = (state == IDLE);
    assign bus.oDone    = done;
    assign bus.oOverrun = overrun;
endmodule

// File: tb/tb_sap2_serial_out_port.sv
// Directed bench for sap2_serial_out_port: three instances (no parity, even,
// odd) at CLKS_PER_BIT=4, checked cycle by cycle against hand-derived frames.
module tb_sap2_serial_out_port;
    localparam int C = 4;

    logic iClk;
    logic iReset_n;
    int   testsRun;
    int   testsFailed;

    sap2_serial_out_port_if #(.DATA_W(8)) bus0 ();
    sap2_serial_out_port_if #(.DATA_W(8)) bus1 ();
    sap2_serial_out_port_if #(.DATA_W(8)) bus2 ();

    sap2_serial_out_port #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .iClk(iClk), .iReset_n(iReset_n), .bus(bus0.slave)
    );
    sap2_serial_out_port #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .iClk(iClk), .iReset_n(iReset_n), .bus(bus1.slave)
    );
    sap2_serial_out_port #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
        .iClk(iClk), .iReset_n(iReset_n), .bus(bus2.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic setIn(input int d, input logic ld, input logic [7:0] dat, input logic clr);
        case (d)
            0:       begin bus0.iLoad = ld; bus0.iData = dat; bus0.iClrErr = clr; end
            1:       begin bus1.iLoad = ld; bus1.iData = dat; bus1.iClrErr = clr; end
            default: begin bus2.iLoad = ld; bus2.iData = dat; bus2.iClrErr = clr; end
        endcase
    endtask

    // Packed {oBitIdx, oOverrun, oDone, oReady, oTx}
    function automatic logic [7:0] outs(input int d);
        case (d)
            0:       return {bus0.oBitIdx, bus0.oOverrun, bus0.oDone, bus0.oReady, bus0.oTx};
            1:       return {bus1.oBitIdx, bus1.oOverrun, bus1.oDone, bus1.oReady, bus1.oTx};
            default: return {bus2.oBitIdx, bus2.oOverrun, bus2.oDone, bus2.oReady, bus2.oTx};
        endcase
    endfunction

    // Issues a load at the next edge and checks every cycle of the frame.
    // Returns right after sampling the oDone cycle, so a following call is back-to-back.
    task automatic runFrame(input string tag, input int d, input logic [7:0] data,
                            input logic expPar, input int ovAt, input logic ovClr);
        int pe;
        int len;
        pe  = (d == 0) ? 0 : 1;
        len = (10 + pe) * C;
        setIn(d, 1'b1, data, 1'b0);
        tick();
        for (int c = 1; c <= len; c++) begin
            int         k;
            logic       eTx;
            logic [3:0] eIdx;
            logic [7:0] o;
            k = (c - 1) / C;
            if (c == len)           begin eTx = 1'b1;        eIdx = 4'd0; end
            else if (k == 0)        begin eTx = 1'b0;        eIdx = 4'd0; end
            else if (k <= 8)        begin eTx = data[k-1];   eIdx = 4'(k); end
            else if (k == 9 && pe == 1) begin eTx = expPar;  eIdx = 4'd9; end
            else                    begin eTx = 1'b1;        eIdx = 4'(9 + pe); end
            o = outs(d);
            check($sformatf("%s c%0d tx", tag, c), 32'(o[0]), 32'(eTx));
            check($sformatf("%s c%0d ready", tag, c), 32'(o[1]), 32'(c == len));
            check($sformatf("%s c%0d done", tag, c), 32'(o[2]), 32'(c == len));
            check($sformatf("%s c%0d idx", tag, c), 32'(o[7:4]), 32'(eIdx));
            if (c == ovAt)          setIn(d, 1'b1, 8'hFF, ovClr);
            else if (c == ovAt + 1) setIn(d, 1'b0, 8'h00, 1'b0);
            else if (c == 1)        setIn(d, 1'b0, 8'h00, 1'b0);
            if (c < len) tick();
        end
    endtask

    initial begin
        logic [7:0] o;
        testsRun    = 0;
        testsFailed = 0;
        iReset_n    = 1'b0;
        for (int d = 0; d < 3; d++) setIn(d, 1'b0, 8'h00, 1'b0);
        #2;
        for (int d = 0; d < 3; d++) begin
            o = outs(d);
            check($sformatf("reset d%0d outputs", d), 32'(o), 32'h02 | 32'h01);
        end
        tick();
        iReset_n = 1'b1;

        for (int c = 0; c < 50; c++) begin
            tick();
            o = outs(0);
            check($sformatf("idle c%0d", c), 32'(o[3:0]), 32'b0011);
        end

        runFrame("A5", 0, 8'hA5, 1'b0, 0, 1'b0);
        repeat (3) tick();
        runFrame("07even", 1, 8'h07, 1'b1, 0, 1'b0);
        repeat (3) tick();
        runFrame("07odd", 2, 8'h07, 1'b0, 0, 1'b0);
        repeat (3) tick();

        runFrame("3Cov", 0, 8'h3C, 1'b0, 12, 1'b0);
        o = outs(0);
        check("overrun set", 32'(o[3]), 32'd1);
        setIn(0, 1'b0, 8'h00, 1'b1);
        tick();
        setIn(0, 1'b0, 8'h00, 1'b0);
        o = outs(0);
        check("overrun cleared", 32'(o[3]), 32'd0);

        runFrame("3Cclr", 0, 8'h3C, 1'b0, 5, 1'b1);
        o = outs(0);
        check("overrun set beats clear", 32'(o[3]), 32'd1);
        setIn(0, 1'b0, 8'h00, 1'b1);
        tick();
        setIn(0, 1'b0, 8'h00, 1'b0);
        tick();

        runFrame("01b2b", 0, 8'h01, 1'b0, 0, 1'b0);
        runFrame("80b2b", 0, 8'h80, 1'b0, 0, 1'b0);
        repeat (3) tick();

        // 0x55 bit 3 is 0, so the line is low at cycle 17 just before reset.
        setIn(0, 1'b1, 8'h55, 1'b0);
        tick();
        setIn(0, 1'b0, 8'h00, 1'b0);
        repeat (16) tick();
        o = outs(0);
        check("55 c17 tx", 32'(o[0]), 32'd0);
        check("55 c17 ready", 32'(o[1]), 32'd0);
        iReset_n = 1'b0;
        #1;
        o = outs(0);
        check("mid-frame reset outputs", 32'(o), 32'h03);
        tick();
        iReset_n = 1'b1;
        tick();
        runFrame("C3", 0, 8'hC3, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
